// File: rtl/ram_arb_pkg.sv
// Shared types and sizes for the RAM port-2 arbiter slice.
package ram_arb_pkg;

    localparam int unsigned ADDR_W    = 13;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned BE_W      = DATA_W / 8;
    localparam int unsigned RAM_DEPTH = 8192;
    localparam int unsigned HOLD_W    = 4;

    // Requester identity carried down the read-valid pipeline
    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } master_id_e;

    // One single-beat request as presented to the RAM port
    typedef struct packed {
        logic [ADDR_W-1:0] address;
        logic [BE_W-1:0]   byteenable;
        logic [DATA_W-1:0] writedata;
        logic              write;
        logic              read;
    } ram_req_t;

    // Bundle a master's request; write wins if read and write are both high
    function automatic ram_req_t pack_req(
        input logic [ADDR_W-1:0] address,
        input logic [BE_W-1:0]   byteenable,
        input logic [DATA_W-1:0] writedata,
        input logic              write,
        input logic              read
    );
        ram_req_t r;
        r.address    = address;
        r.byteenable = byteenable;
        r.writedata  = writedata;
        r.write      = write;
        r.read       = read & ~write;
        return r;
    endfunction

endpackage

// File: rtl/ram_arb_grant.sv
// Two-requester fixed-priority grant with a starvation bound for the low-priority side.
module ram_arb_grant
    import ram_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic req0_i,
    input  logic req1_i,
    output logic gnt0_c_o,
    output logic gnt1_c_o
);

    logic [HOLD_W-1:0] hold_cnt_q;
    logic [HOLD_W-1:0] hold_cnt_d;
    logic              gnt0;
    logic              gnt1;

    // Same-cycle grant: req1 wins only when req0 is idle or req1 has waited long enough
    always_comb begin
        gnt1 = req1_i & (~req0_i | (hold_cnt_q == HOLD_W'(MAX_HOLD)));
        gnt0 = req0_i & ~gnt1;
    end

    // Count consecutive req0 grants taken while req1 is waiting
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (gnt1 || !req1_i) begin
            hold_cnt_d = '0;
        end else if (gnt0) begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
    end

    // Hold counter register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_cnt_q <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign gnt0_c_o = gnt0;
    assign gnt1_c_o = gnt1;

endmodule

// File: rtl/ram_port2_arbiter.sv
// Shares RAM port 2 between the capture writer (m0) and the LED stream reader (m1).
module ram_port2_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,

    output logic [ADDR_W-1:0] address2,
    output logic [BE_W-1:0]   byteenable2,
    output logic              chipselect2,
    output logic              write2,
    output logic [DATA_W-1:0] writedata2,
    output logic              clken2,
    input  logic [DATA_W-1:0] readdata2
);

    logic       req0;
    logic       req1;
    logic       gnt0;
    logic       gnt1;
    ram_req_t   m0_req;
    ram_req_t   m1_req;
    ram_req_t   ram_sel;

    logic       rd_pend_q;
    logic       rd_pend_d;
    master_id_e rd_id_q;
    master_id_e rd_id_d;

    assign req0   = m0_read | m0_write;
    assign req1   = m1_read | m1_write;
    assign m0_req = pack_req(m0_address, m0_byteenable, m0_writedata, m0_write, m0_read);
    assign m1_req = pack_req(m1_address, m1_byteenable, m1_writedata, m1_write, m1_read);

    ram_arb_grant #(
        .MAX_HOLD (MAX_HOLD)
    ) u_grant (
        .clk      (clk),
        .reset_n  (reset_n),
        .req0_i   (req0),
        .req1_i   (req1),
        .gnt0_c_o (gnt0),
        .gnt1_c_o (gnt1)
    );

    // Route the granted request to the RAM; an idle port sees all zeros
    always_comb begin
        ram_sel = '0;
        if (gnt1) begin
            ram_sel = m1_req;
        end else if (gnt0) begin
            ram_sel = m0_req;
        end
    end

    assign address2       = ram_sel.address;
    assign byteenable2    = ram_sel.byteenable;
    assign writedata2     = ram_sel.writedata;
    assign write2         = ram_sel.write;
    assign chipselect2    = gnt0 | gnt1;
    assign clken2         = 1'b1;

    assign m0_waitrequest = req0 & ~gnt0;
    assign m1_waitrequest = req1 & ~gnt1;

    // Remember who owns the read accepted this cycle
    always_comb begin
        rd_pend_d = ram_sel.read;
        rd_id_d   = gnt1 ? M1 : M0;
    end

    // Read-valid pipeline; reset drops any read in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_pend_q <= 1'b0;
            rd_id_q   <= M0;
        end else begin
            rd_pend_q <= rd_pend_d;
            rd_id_q   <= rd_id_d;
        end
    end

    assign m0_readdatavalid = rd_pend_q & (rd_id_q == M0);
    assign m1_readdatavalid = rd_pend_q & (rd_id_q == M1);
    assign m0_readdata      = readdata2;
    assign m1_readdata      = readdata2;

endmodule

// File: tb/tb_ram_port2_arbiter.sv
// Directed bench for ram_port2_arbiter with a behavioural port-2 RAM.
module tb_ram_port2_arbiter;

    localparam int unsigned AW = 13;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = DW / 8;

    logic          clk;
    logic          reset_n;
    logic [AW-1:0] m0_address, m1_address;
    logic          m0_read, m0_write, m1_read, m1_write;
    logic [BW-1:0] m0_byteenable, m1_byteenable;
    logic [DW-1:0] m0_writedata, m1_writedata;
    logic          m0_waitrequest, m1_waitrequest;
    logic [DW-1:0] m0_readdata, m1_readdata;
    logic          m0_readdatavalid, m1_readdatavalid;
    logic [AW-1:0] address2;
    logic [BW-1:0] byteenable2;
    logic          chipselect2, write2, clken2;
    logic [DW-1:0] writedata2;
    logic [DW-1:0] readdata2;

    int n_cmp = 0;
    int n_err = 0;

    ram_port2_arbiter dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .m0_address       (m0_address),
        .m0_read          (m0_read),
        .m0_write         (m0_write),
        .m0_byteenable    (m0_byteenable),
        .m0_writedata     (m0_writedata),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_address       (m1_address),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_byteenable    (m1_byteenable),
        .m1_writedata     (m1_writedata),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .address2         (address2),
        .byteenable2      (byteenable2),
        .chipselect2      (chipselect2),
        .write2           (write2),
        .writedata2       (writedata2),
        .clken2           (clken2),
        .readdata2        (readdata2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Port-2 RAM: byte-lane writes, registered read data one edge after the address
    logic [DW-1:0] mem [0:8191];
    bit            ram_loaded = 1'b0;
    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int a = 0; a < 8192; a++) mem[a] = '0;
            mem[13'h0001] = 32'h0101_0101;
            mem[13'h0002] = 32'h0202_0202;
            mem[13'h0005] = 32'h5555_5555;
            mem[13'h0010] = 32'hAABB_CCDD;
            mem[13'h1FFF] = 32'hDEAD_BEEF;
            ram_loaded = 1'b1;
        end
        if (chipselect2) begin
            if (write2) begin
                for (int b = 0; b < 4; b++)
                    if (byteenable2[b]) mem[address2][8*b +: 8] <= writedata2[8*b +: 8];
            end else begin
                readdata2 <= mem[address2];
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before the end of the sequence");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_all();
        m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
        m0_address = '0; m1_address = '0;
        m0_byteenable = '0; m1_byteenable = '0;
        m0_writedata = '0; m1_writedata = '0;
    endtask

    int m1_wait_cycles;

    initial begin
        idle_all();
        reset_n = 1'b0;
        readdata2 = '0;

        // Reset held with both masters requesting
        m0_read = 1; m0_address = 13'h0005;
        m1_read = 1; m1_address = 13'h0006;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_m0_rdv", 32'(m0_readdatavalid), 32'd0);
            check("rst_m1_rdv", 32'(m1_readdatavalid), 32'd0);
        end
        reset_n = 1'b1;
        #1;
        check("post_rst_m0_wait", 32'(m0_waitrequest), 32'd0);
        check("post_rst_m1_wait", 32'(m1_waitrequest), 32'd1);
        check("post_rst_addr2", 32'(address2), 32'h5);
        check("post_rst_clken2", 32'(clken2), 32'd1);
        tick();
        check("post_rst_m0_rdv", 32'(m0_readdatavalid), 32'd1);
        check("post_rst_m0_rdata", m0_readdata, 32'h5555_5555);
        check("post_rst_m1_rdv", 32'(m1_readdatavalid), 32'd0);
        idle_all();
        #1;
        check("idle_cs2", 32'(chipselect2), 32'd0);
        check("idle_addr2", 32'(address2), 32'd0);
        check("idle_m0_wait", 32'(m0_waitrequest), 32'd0);
        check("idle_m1_wait", 32'(m1_waitrequest), 32'd0);
        tick();
        check("idle_m0_rdv", 32'(m0_readdatavalid), 32'd0);

        // m1 solo read at the top address
        m1_read = 1; m1_address = 13'h1FFF;
        #1;
        check("solo_m1_wait", 32'(m1_waitrequest), 32'd0);
        check("solo_cs2", 32'(chipselect2), 32'd1);
        check("solo_addr2", 32'(address2), 32'h1FFF);
        check("solo_write2", 32'(write2), 32'd0);
        tick();
        idle_all();
        check("solo_m1_rdv", 32'(m1_readdatavalid), 32'd1);
        check("solo_m1_rdata", m1_readdata, 32'hDEAD_BEEF);
        check("solo_m0_rdv", 32'(m0_readdatavalid), 32'd0);
        tick();
        check("solo_m1_rdv_end", 32'(m1_readdatavalid), 32'd0);

        // Starvation bound: m0 writes every cycle, m1 read pending
        m0_write = 1; m0_address = 13'h0020; m0_byteenable = 4'hF; m0_writedata = 32'hCAFE_0000;
        m1_read = 1; m1_address = 13'h1FFF;
        m1_wait_cycles = 0;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) m1_read = 0;
            #1;
            if (m1_waitrequest) m1_wait_cycles++;
            check($sformatf("starve_m1_wait_%0d", i), 32'(m1_waitrequest), (i < 4) ? 32'd1 : 32'd0);
            check($sformatf("starve_m0_wait_%0d", i), 32'(m0_waitrequest), (i == 4) ? 32'd1 : 32'd0);
            check($sformatf("starve_write2_%0d", i), 32'(write2), (i == 4) ? 32'd0 : 32'd1);
            if (i == 5) begin
                check("starve_m1_rdv", 32'(m1_readdatavalid), 32'd1);
                check("starve_m1_rdata", m1_readdata, 32'hDEAD_BEEF);
            end
            tick();
        end
        check("starve_m1_wait_total", 32'(m1_wait_cycles), 32'd4);
        idle_all();
        tick();

        // Byte-lane write then read back through m1
        m0_write = 1; m0_address = 13'h0010; m0_byteenable = 4'b0101; m0_writedata = 32'h1122_3344;
        #1;
        check("bw_m0_wait", 32'(m0_waitrequest), 32'd0);
        check("bw_write2", 32'(write2), 32'd1);
        check("bw_be2", 32'(byteenable2), 32'h5);
        check("bw_wdata2", writedata2, 32'h1122_3344);
        tick();
        idle_all();
        check("bw_no_rdv", 32'(m0_readdatavalid), 32'd0);
        m1_read = 1; m1_address = 13'h0010;
        #1;
        check("bw_rd_m1_wait", 32'(m1_waitrequest), 32'd0);
        tick();
        idle_all();
        check("bw_rd_m1_rdv", 32'(m1_readdatavalid), 32'd1);
        check("bw_rd_m1_rdata", m1_readdata, 32'hAA22_CC44);
        tick();

        // Interleaved back-to-back reads m0 then m1
        m0_read = 1; m0_address = 13'h0001;
        tick();
        m0_read = 0;
        m1_read = 1; m1_address = 13'h0002;
        check("il_m0_rdv", 32'(m0_readdatavalid), 32'd1);
        check("il_m0_rdata", m0_readdata, 32'h0101_0101);
        check("il_m1_rdv_early", 32'(m1_readdatavalid), 32'd0);
        tick();
        idle_all();
        check("il_m1_rdv", 32'(m1_readdatavalid), 32'd1);
        check("il_m1_rdata", m1_readdata, 32'h0202_0202);
        check("il_m0_rdv_late", 32'(m0_readdatavalid), 32'd0);
        tick();
        check("il_m0_rdv_end", 32'(m0_readdatavalid), 32'd0);
        check("il_m1_rdv_end", 32'(m1_readdatavalid), 32'd0);

        // Read and write together: the write wins and no read response follows
        m0_read = 1; m0_write = 1; m0_address = 13'h0030; m0_byteenable = 4'hF; m0_writedata = 32'h1234_5678;
        #1;
        check("ww_write2", 32'(write2), 32'd1);
        tick();
        idle_all();
        check("ww_no_rdv", 32'(m0_readdatavalid), 32'd0);
        tick();

        // Reset between acceptance and response drops the read
        m1_read = 1; m1_address = 13'h1FFF;
        tick();
        idle_all();
        reset_n = 1'b0;
        #1;
        check("mr_m1_rdv_in_rst", 32'(m1_readdatavalid), 32'd0);
        #2;
        reset_n = 1'b1;
        tick();
        check("mr_m1_rdv_after", 32'(m1_readdatavalid), 32'd0);
        tick();
        check("mr_m1_rdv_after2", 32'(m1_readdatavalid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
